// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encodings and
// the default operand width.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock LSB first, with a start/done handshake.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic             cmsb;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-2:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;

   fa_cell u_fa (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_c)
   );

   // The result register only keeps the WIDTH-1 bits already produced; the
   // final full word is formed with the MSB bit computed in the last cycle.
   assign res_next = {fa_s, res_sh};
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (last_bit) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Subtraction feeds inverted b with a carry-in of 1 (two's complement).
   // cmsb holds the carry out of bit WIDTH-2, i.e. the carry into the MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         carry  <= 1'b0;
         cmsb   <= 1'b0;
         cnt    <= '0;
         res_sh <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b ^ {WIDTH{sub}};
                  carry <= sub;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               res_sh <= res_next[WIDTH-1:1];
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_c;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 2)) begin
                  cmsb <= fa_c;
               end
               if (last_bit) begin
                  sum  <= res_next;
                  cout <= fa_c;
                  ovf  <= cmsb ^ fa_c;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised checks of serial_addsub at WIDTH 8, 2 and 16.
module tb_serial_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        start8, sub8, busy8, done8, cout8, ovf8;
   logic [7:0]  a8, b8, sum8;
   logic        start2, sub2, busy2, done2, cout2, ovf2;
   logic [1:0]  a2, b2, sum2;
   logic        start16, sub16, busy16, done16, cout16, ovf16;
   logic [15:0] a16, b16, sum16;

   int tests_run    = 0;
   int tests_failed = 0;

   serial_addsub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_addsub #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   serial_addsub #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
   );

   // Launches one 8-bit operation and waits (bounded) for done.
   // lat counts edges from the sampling edge; busy_n counts busy cycles seen.
   task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                          output int lat, output int busy_n);
      @(negedge clk);
      a8 = av; b8 = bv; sub8 = sv; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = 1;
      busy_n = 0;
      while (!done8 && lat < 40) begin
         if (busy8) busy_n++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
         tests_failed++;
         $display("[TB] FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                  busy8, done8, sum8, cout8, ovf8);
      end
      tests_run++;
      if ({busy2, done2, sum2, cout2, ovf2} !== 6'h00 ||
          {busy16, done16, sum16, cout16, ovf16} !== 20'h00000) begin
         tests_failed++;
         $display("[TB] FAIL reset_w2_w16: got sum2=%h sum16=%h busy2=%b busy16=%b expected all 0",
                  sum2, sum16, busy2, busy16);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat, busy_n;
      run_op8(8'h3C, 8'h5A, 1'b0, lat, busy_n);
      tests_run++;
      if (lat !== 9 || busy_n !== 8) begin
         tests_failed++;
         $display("[TB] FAIL add_latency: got lat=%0d busy=%0d expected lat=9 busy=8", lat, busy_n);
      end
      tests_run++;
      if (sum8 !== 8'h96 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL add_result: got sum=%h cout=%b ovf=%b expected 96 0 1", sum8, cout8, ovf8);
      end
      @(negedge clk);
      tests_run++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL done_pulse: got done=%b busy=%b expected 0 0", done8, busy8);
      end
      a8 = 8'h11; b8 = 8'h22;
      repeat (5) @(negedge clk);
      tests_run++;
      if (sum8 !== 8'h96) begin
         tests_failed++;
         $display("[TB] FAIL sum_hold: got %h expected 96", sum8);
      end
   endtask

   task automatic test_add_carry();
      int lat, busy_n;
      run_op8(8'hFF, 8'h01, 1'b0, lat, busy_n);
      tests_run++;
      if (lat !== 9 || sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL add_wrap: got lat=%0d sum=%h cout=%b ovf=%b expected 9 00 1 0",
                  lat, sum8, cout8, ovf8);
      end
   endtask

   task automatic test_sub();
      int lat, busy_n;
      run_op8(8'h05, 8'h07, 1'b1, lat, busy_n);
      tests_run++;
      if (lat !== 9 || sum8 !== 8'hFE || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL sub_borrow: got lat=%0d sum=%h cout=%b ovf=%b expected 9 fe 0 0",
                  lat, sum8, cout8, ovf8);
      end
      run_op8(8'h80, 8'h01, 1'b1, lat, busy_n);
      tests_run++;
      if (lat !== 9 || sum8 !== 8'h7F || cout8 !== 1'b1 || ovf8 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL sub_ovf: got lat=%0d sum=%h cout=%b ovf=%b expected 9 7f 1 1",
                  lat, sum8, cout8, ovf8);
      end
   endtask

   // Extra start pulses (with different operands) land in RUN and in DONE.
   task automatic test_ignore_start();
      int pulses, first_lat;
      pulses = 0;
      first_lat = 0;
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (done8) begin
            pulses++;
            if (pulses == 1) first_lat = c;
         end
         if (c == 3) begin
            start8 = 1'b1; a8 = 8'h77;
         end else if (done8) begin
            start8 = 1'b1; a8 = 8'h55; sub8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
      end
      tests_run++;
      if (pulses !== 1 || first_lat !== 9) begin
         tests_failed++;
         $display("[TB] FAIL ignore_start_pulses: got pulses=%0d lat=%0d expected 1 9", pulses, first_lat);
      end
      tests_run++;
      if (sum8 !== 8'h46 || cout8 !== 1'b0 || ovf8 !== 1'b0 || busy8 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ignore_start_result: got sum=%h cout=%b ovf=%b busy=%b expected 46 0 0 0",
                  sum8, cout8, ovf8, busy8);
      end
   endtask

   task automatic test_reset_mid_run();
      int pulses, lat, busy_n;
      pulses = 0;
      @(negedge clk);
      a8 = 8'hF0; b8 = 8'h0F; sub8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (busy8 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL midrun_busy: got %b expected 1", busy8);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
         tests_failed++;
         $display("[TB] FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                  busy8, done8, sum8, cout8, ovf8);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done8) pulses++;
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("[TB] FAIL midrun_no_done: got %0d done pulses expected 0", pulses);
      end
      run_op8(8'h3C, 8'h5A, 1'b1, lat, busy_n);
      tests_run++;
      if (lat !== 9 || sum8 !== 8'hE2 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL after_reset_op: got lat=%0d sum=%h cout=%b ovf=%b expected 9 e2 0 0",
                  lat, sum8, cout8, ovf8);
      end
   endtask

   // Random operations on the 2- or 16-bit instance against an arithmetic model.
   task automatic test_random(input int w);
      logic [15:0] mask, av, bv, bx, exp_sum, got_sum;
      logic [16:0] full;
      logic        sv, exp_c, exp_o, got_c, got_o, sa, sb, ss;
      int          lat, busy_n;
      mask = (w == 16) ? 16'hFFFF : 16'h0003;
      for (int i = 0; i < 1000; i++) begin
         av = 16'($urandom) & mask;
         bv = 16'($urandom) & mask;
         sv = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (w == 2) begin
            a2 = av[1:0]; b2 = bv[1:0]; sub2 = sv; start2 = 1'b1;
         end else begin
            a16 = av; b16 = bv; sub16 = sv; start16 = 1'b1;
         end
         @(negedge clk);
         start2 = 1'b0;
         start16 = 1'b0;
         lat = 1;
         busy_n = 0;
         while (!((w == 2) ? done2 : done16) && lat < 40) begin
            if ((w == 2) ? busy2 : busy16) busy_n++;
            @(negedge clk);
            lat++;
         end
         bx = (sv ? ~bv : bv) & mask;
         full = {1'b0, av} + {1'b0, bx} + {16'b0, sv};
         exp_sum = full[15:0] & mask;
         exp_c = full[w];
         sa = av[w-1];
         sb = bv[w-1];
         ss = exp_sum[w-1];
         exp_o = sv ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
         got_sum = (w == 2) ? {14'b0, sum2} : sum16;
         got_c = (w == 2) ? cout2 : cout16;
         got_o = (w == 2) ? ovf2 : ovf16;
         tests_run++;
         if (got_sum !== exp_sum || got_c !== exp_c || got_o !== exp_o || busy_n !== w || lat !== w + 1) begin
            tests_failed++;
            $display("[TB] FAIL random_w%0d a=%h b=%h sub=%b: got sum=%h cout=%b ovf=%b busy=%0d lat=%0d expected %h %b %b %0d %0d",
                     w, av, bv, sv, got_sum, got_c, got_o, busy_n, lat, exp_sum, exp_c, exp_o, w, w + 1);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
      start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
      start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_add();
      test_add_carry();
      test_sub();
      test_ignore_start();
      test_reset_mid_run();
      test_random(2);
      test_random(16);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
